// File: rtl/pipelined_barrel.sv
// Pipelined barrel shifter: logical, arithmetic, rotate and ones-fill modes over STAGES valid/ready stages.
// Optional out_carry/out_zero flags are enabled by defining PIPELINED_BARREL_FLAGS_EN.
module pipelined_barrel #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH)-1:0] in_count,
    input  logic                     in_left,
    input  logic [1:0]               in_type,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data
`ifdef PIPELINED_BARREL_FLAGS_EN
    ,
    output logic                     out_carry,
    output logic                     out_zero
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam int P  = (CW + STAGES - 1) / STAGES;

    localparam logic [1:0] T_LOG = 2'd0;
    localparam logic [1:0] T_ARI = 2'd1;
    localparam logic [1:0] T_ROT = 2'd2;
    localparam logic [1:0] T_ONE = 2'd3;

    function automatic logic [WIDTH-1:0] shift_level(input logic [WIDTH-1:0] d, input int k,
                                                     input logic left, input logic [1:0] typ);
        int               sh;
        logic             fill;
        logic [WIDTH-1:0] ones;
        logic [WIDTH-1:0] r;
        sh   = 1 << k;
        ones = '1;
        if (left) begin
            fill = (typ == T_ONE);
            if (typ == T_ROT) r = (d << sh) | (d >> (WIDTH - sh));
            else              r = (d << sh) | (fill ? ~(ones << sh) : '0);
        end else begin
            // arithmetic fill reads the current MSB: earlier right levels already replicated the sign
            fill = (typ == T_ONE) || ((typ == T_ARI) && d[WIDTH-1]);
            if (typ == T_ROT) r = (d >> sh) | (d << (WIDTH - sh));
            else              r = (d >> sh) | (fill ? ~(ones >> sh) : '0);
        end
        return r;
    endfunction

    // The last bit leaving a level; chaining levels low-to-high leaves in_data[WIDTH-count] / in_data[count-1].
    function automatic logic carry_level(input logic [WIDTH-1:0] d, input int k, input logic left);
        int               sh;
        logic [WIDTH-1:0] t;
        sh = 1 << k;
        t  = left ? (d >> (WIDTH - sh)) : (d >> (sh - 1));
        return t[0];
    endfunction

    logic [STAGES-1:0] vld_vec;
    logic [STAGES-1:0] rdy_nxt;

    always_comb begin
        logic r;
        r = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            rdy_nxt[i] = r;
            r = !vld_vec[i] || r;
        end
        in_ready = r;
    end

    for (genvar i = 0; i < STAGES; i++) begin : g_st
        localparam bit LAST = (i == STAGES - 1);
        localparam int LO   = i * P;
        localparam int HI   = ((i + 1) * P < CW) ? (i + 1) * P : CW;

        logic             src_v;
        logic [WIDTH-1:0] src_d;
        logic [CW-1:0]    src_cnt;
        logic             src_left;
        logic [1:0]       src_type;
        logic [WIDTH-1:0] nxt_d;
        logic             load;
        logic             vld_p;
        logic [WIDTH-1:0] data_p;
`ifdef PIPELINED_BARREL_FLAGS_EN
        logic             src_c;
        logic             nxt_c;
        logic             carry_p;
`endif

        if (i == 0) begin : g_src
            assign src_v    = in_valid;
            assign src_d    = in_data;
            assign src_cnt  = in_count;
            assign src_left = in_left;
            assign src_type = in_type;
`ifdef PIPELINED_BARREL_FLAGS_EN
            assign src_c    = 1'b0;
`endif
        end else begin : g_src
            assign src_v    = g_st[i-1].vld_p;
            assign src_d    = g_st[i-1].data_p;
            assign src_cnt  = g_st[i-1].g_ctl.cnt_p;
            assign src_left = g_st[i-1].g_ctl.left_p;
            assign src_type = g_st[i-1].g_ctl.type_p;
`ifdef PIPELINED_BARREL_FLAGS_EN
            assign src_c    = g_st[i-1].carry_p;
`endif
        end

        always_comb begin
            nxt_d = src_d;
`ifdef PIPELINED_BARREL_FLAGS_EN
            nxt_c = src_c;
`endif
            for (int k = 0; k < CW; k++) begin
                if (k >= LO && k < HI && src_cnt[k]) begin
`ifdef PIPELINED_BARREL_FLAGS_EN
                    nxt_c = carry_level(nxt_d, k, src_left);
`endif
                    nxt_d = shift_level(nxt_d, k, src_left, src_type);
                end
            end
        end

        assign vld_vec[i] = vld_p;
        assign load       = !vld_p || rdy_nxt[i];

        // ---- stage i register boundary ----
        always_ff @(posedge clk) begin
            if (!rst_n)    vld_p <= 1'b0;
            else if (load) vld_p <= src_v;
        end

        always_ff @(posedge clk) begin
            if (LAST && !rst_n) begin
                data_p  <= '0;
`ifdef PIPELINED_BARREL_FLAGS_EN
                carry_p <= 1'b0;
`endif
            end else if (load && src_v) begin
                data_p  <= nxt_d;
`ifdef PIPELINED_BARREL_FLAGS_EN
                carry_p <= nxt_c;
`endif
            end
        end

        if (!LAST) begin : g_ctl
            logic [CW-1:0] cnt_p;
            logic          left_p;
            logic [1:0]    type_p;
            always_ff @(posedge clk) begin
                if (load && src_v) begin
                    cnt_p  <= src_cnt;
                    left_p <= src_left;
                    type_p <= src_type;
                end
            end
        end
    end

    assign out_valid = vld_vec[STAGES-1];
    assign out_data  = g_st[STAGES-1].data_p;
`ifdef PIPELINED_BARREL_FLAGS_EN
    assign out_carry = g_st[STAGES-1].carry_p;
    assign out_zero  = out_valid && (out_data == '0);
`endif

endmodule

// File: tb/tb_pipelined_barrel.sv
// Bench for pipelined_barrel: directed vector table, backpressure and mid-stream reset sequences,
// plus a random sweep comparing STAGES=1/2/5 instances against a bit-level reference model.
module tb_pipelined_barrel;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic [4:0]  in_count;
    logic        in_left;
    logic [1:0]  in_type;
    logic        out_ready;

    logic        ir1, ir2, ir5;
    logic        ov1, ov2, ov5;
    logic [31:0] od1, od2, od5;
`ifdef PIPELINED_BARREL_FLAGS_EN
    logic        oc1, oc2, oc5;
    logic        oz1, oz2, oz5;
`endif

    int errors = 0;
    int checks = 0;

    pipelined_barrel #(.WIDTH(32), .STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir2), .in_data(in_data),
        .in_count(in_count), .in_left(in_left), .in_type(in_type), .out_valid(ov2),
        .out_ready(out_ready), .out_data(od2)
`ifdef PIPELINED_BARREL_FLAGS_EN
        , .out_carry(oc2), .out_zero(oz2)
`endif
    );

    pipelined_barrel #(.WIDTH(32), .STAGES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
        .in_count(in_count), .in_left(in_left), .in_type(in_type), .out_valid(ov1),
        .out_ready(out_ready), .out_data(od1)
`ifdef PIPELINED_BARREL_FLAGS_EN
        , .out_carry(oc1), .out_zero(oz1)
`endif
    );

    pipelined_barrel #(.WIDTH(32), .STAGES(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir5), .in_data(in_data),
        .in_count(in_count), .in_left(in_left), .in_type(in_type), .out_valid(ov5),
        .out_ready(out_ready), .out_data(od5)
`ifdef PIPELINED_BARREL_FLAGS_EN
        , .out_carry(oc5), .out_zero(oz5)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  cnt;
        logic        left;
        logic [1:0]  typ;
        logic [31:0] exp;
        logic        carry;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  cnt;
        logic        left;
        logic [1:0]  typ;
    } beat_t;

    function automatic logic [32:0] model(input beat_t b);
        logic [31:0] r;
        logic        c;
        int          src;
        for (int j = 0; j < 32; j++) begin
            if (b.left) begin
                src = j - int'(b.cnt);
                if (src >= 0)         r[j] = b.d[src];
                else if (b.typ == 2)  r[j] = b.d[src + 32];
                else                  r[j] = (b.typ == 3);
            end else begin
                src = j + int'(b.cnt);
                if (src < 32)         r[j] = b.d[src];
                else if (b.typ == 2)  r[j] = b.d[src - 32];
                else                  r[j] = (b.typ == 3) || (b.typ == 1 && b.d[31]);
            end
        end
        if (b.cnt == 0)   c = 1'b0;
        else if (b.left)  c = b.d[32 - int'(b.cnt)];
        else              c = b.d[int'(b.cnt) - 1];
        return {c, r};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive(input beat_t b);
        in_valid = 1'b1;
        in_data  = b.d;
        in_count = b.cnt;
        in_left  = b.left;
        in_type  = b.typ;
    endtask

    task automatic chk_dut(input string nm, input int lat, input int c, input logic v,
                           input logic [31:0] d, input logic fc, input logic fz, input beat_t hist[80]);
        logic [32:0] m;
        int          idx;
        idx = c - lat + 1;
        if (idx < 0) begin
            chk({nm, "_valid_early"}, {31'd0, v}, 32'd0);
        end else begin
            m = model(hist[idx]);
            chk({nm, "_valid"}, {31'd0, v}, 32'd1);
            chk({nm, "_data"}, d, m[31:0]);
`ifdef PIPELINED_BARREL_FLAGS_EN
            chk({nm, "_carry"}, {31'd0, fc}, {31'd0, m[32]});
            chk({nm, "_zero"}, {31'd0, fz}, {31'd0, (m[31:0] == 32'd0)});
`else
            if (fc !== fz) begin end
`endif
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        vt[19];
        beat_t       b;
        beat_t       bp[4];
        beat_t       hist[80];
        logic [32:0] m;
        logic        acc;
        int          n_in, n_out, gaps, stale;

        vt[0]  = '{32'h0000_0002, 5'd1,  1'b1, 2'd0, 32'h0000_0004, 1'b0};
        vt[1]  = '{32'h0000_0002, 5'd10, 1'b1, 2'd0, 32'h0000_0800, 1'b0};
        vt[2]  = '{32'h8000_0000, 5'd2,  1'b0, 2'd1, 32'hE000_0000, 1'b0};
        vt[3]  = '{32'h0000_0018, 5'd5,  1'b0, 2'd0, 32'h0000_0000, 1'b1};
        vt[4]  = '{32'h0000_0007, 5'd3,  1'b1, 2'd3, 32'h0000_003F, 1'b0};
        vt[5]  = '{32'hE000_0000, 5'd3,  1'b1, 2'd2, 32'h0000_0007, 1'b1};
        vt[6]  = '{32'h0000_0007, 5'd3,  1'b0, 2'd2, 32'hE000_0000, 1'b1};
        vt[7]  = '{32'hA5A5_0F0F, 5'd0,  1'b1, 2'd0, 32'hA5A5_0F0F, 1'b0};
        vt[8]  = '{32'hA5A5_0F0F, 5'd0,  1'b0, 2'd1, 32'hA5A5_0F0F, 1'b0};
        vt[9]  = '{32'hA5A5_0F0F, 5'd0,  1'b1, 2'd2, 32'hA5A5_0F0F, 1'b0};
        vt[10] = '{32'hA5A5_0F0F, 5'd0,  1'b0, 2'd3, 32'hA5A5_0F0F, 1'b0};
        vt[11] = '{32'h0000_00F0, 5'd4,  1'b0, 2'd3, 32'hF000_000F, 1'b0};
        vt[12] = '{32'h7FFF_FFFF, 5'd31, 1'b0, 2'd1, 32'h0000_0000, 1'b1};
        vt[13] = '{32'h8000_0001, 5'd31, 1'b0, 2'd1, 32'hFFFF_FFFF, 1'b0};
        vt[14] = '{32'h0000_0001, 5'd31, 1'b1, 2'd0, 32'h8000_0000, 1'b0};
        vt[15] = '{32'h0000_0001, 5'd1,  1'b0, 2'd0, 32'h0000_0000, 1'b1};
        vt[16] = '{32'h0000_0001, 5'd31, 1'b1, 2'd3, 32'hFFFF_FFFF, 1'b0};
        vt[17] = '{32'h8000_0000, 5'd4,  1'b1, 2'd1, 32'h0000_0000, 1'b0};
        vt[18] = '{32'h1234_5678, 5'd8,  1'b0, 2'd2, 32'h7812_3456, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_count = '0; in_left = 1'b0;
        in_type = 2'd0; out_ready = 1'b1;

        tick();
        chk("rst_out_valid", {31'd0, ov2}, 32'd0);
        chk("rst_out_data", od2, 32'd0);
        chk("rst_in_ready", {31'd0, ir2}, 32'd1);
`ifdef PIPELINED_BARREL_FLAGS_EN
        chk("rst_out_carry", {31'd0, oc2}, 32'd0);
        chk("rst_out_zero", {31'd0, oz2}, 32'd0);
`endif
        tick();
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            b = '{vt[i].d, vt[i].cnt, vt[i].left, vt[i].typ};
            drive(b);
            chk($sformatf("vec%0d_in_ready", i), {31'd0, ir2}, 32'd1);
            tick();
            in_valid = 1'b0;
            chk($sformatf("vec%0d_early_valid", i), {31'd0, ov2}, 32'd0);
            tick();
            chk($sformatf("vec%0d_valid", i), {31'd0, ov2}, 32'd1);
            chk($sformatf("vec%0d_data", i), od2, vt[i].exp);
`ifdef PIPELINED_BARREL_FLAGS_EN
            chk($sformatf("vec%0d_carry", i), {31'd0, oc2}, {31'd0, vt[i].carry});
            chk($sformatf("vec%0d_zero", i), {31'd0, oz2}, {31'd0, (vt[i].exp == 32'd0)});
`endif
        end
        tick();

        // backpressure: fill the two stages, then stall, then drain
        bp[0] = '{32'h0000_0001, 5'd3, 1'b1, 2'd0};
        bp[1] = '{32'h8000_0000, 5'd4, 1'b0, 2'd1};
        bp[2] = '{32'h1234_5678, 5'd8, 1'b1, 2'd2};
        bp[3] = '{32'h0000_000F, 5'd4, 1'b0, 2'd3};
        out_ready = 1'b0;
        drive(bp[0]);
        chk("bp_accept0", {31'd0, ir2}, 32'd1);
        tick();
        drive(bp[1]);
        chk("bp_accept1", {31'd0, ir2}, 32'd1);
        tick();
        drive(bp[2]);
        m = model(bp[0]);
        chk("bp_full_in_ready", {31'd0, ir2}, 32'd0);
        chk("bp_full_valid", {31'd0, ov2}, 32'd1);
        chk("bp_full_data", od2, m[31:0]);
        tick();
        tick();
        chk("bp_hold_in_ready", {31'd0, ir2}, 32'd0);
        chk("bp_hold_data", od2, m[31:0]);
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", {31'd0, ir2}, 32'd1);
        n_in = 2; n_out = 0; gaps = 0;
        for (int c = 0; c < 12 && n_out < 4; c++) begin
            acc = in_valid && ir2;
            if (ov2) begin
                m = model(bp[n_out]);
                chk($sformatf("bp_drain%0d", n_out), od2, m[31:0]);
                n_out++;
            end else if (n_out > 0) begin
                gaps++;
            end
            tick();
            if (acc) begin
                n_in++;
                if (n_in < 4) drive(bp[n_in]);
                else          in_valid = 1'b0;
            end
        end
        chk("bp_drain_count", n_out, 32'd4);
        chk("bp_drain_gaps", gaps, 32'd0);
        in_valid = 1'b0;
        tick();

        // reset with two beats in flight
        out_ready = 1'b0;
        drive('{32'hDEAD_BEEF, 5'd4, 1'b1, 2'd0});
        tick();
        drive('{32'h0BAD_F00D, 5'd8, 1'b0, 2'd1});
        tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_valid", {31'd0, ov2}, 32'd0);
        chk("mid_rst_data", od2, 32'd0);
        chk("mid_rst_in_ready", {31'd0, ir2}, 32'd1);
        out_ready = 1'b1;
        stale = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (ov2) stale++;
        end
        chk("mid_rst_stale", stale, 32'd0);
        b = '{32'h0000_00C3, 5'd2, 1'b1, 2'd2};
        drive(b);
        tick();
        in_valid = 1'b0;
        tick();
        chk("post_rst_valid", {31'd0, ov2}, 32'd1);
        chk("post_rst_data", od2, 32'h0000_030C);

        // random sweep across STAGES=1, 2 and 5, full rate with no backpressure
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 80; c++) begin
            hist[c] = '{$urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                        2'($urandom_range(0, 3))};
            if (c % 16 == 0) hist[c].cnt = 5'd0;
            drive(hist[c]);
            tick();
`ifdef PIPELINED_BARREL_FLAGS_EN
            chk_dut("rnd_s1", 1, c, ov1, od1, oc1, oz1, hist);
            chk_dut("rnd_s2", 2, c, ov2, od2, oc2, oz2, hist);
            chk_dut("rnd_s5", 5, c, ov5, od5, oc5, oz5, hist);
`else
            chk_dut("rnd_s1", 1, c, ov1, od1, 1'b0, 1'b0, hist);
            chk_dut("rnd_s2", 2, c, ov2, od2, 1'b0, 1'b0, hist);
            chk_dut("rnd_s5", 5, c, ov5, od5, 1'b0, 1'b0, hist);
`endif
        end
        chk("rnd_in_ready", {29'd0, ir1, ir2, ir5}, 32'd7);
        in_valid = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipelined_barrel.md
Name: pipelined_barrel

Overview:
- Parametrised, pipelined successor to the combinational barrel shifter.
- Shifts or rotates a WIDTH-bit operand left or right by a run-time count in one of four modes.
- Shift levels are split across STAGES register stages, with a valid/ready handshake on input and output.
- Sits between operand staging and the writeback mux of the ALU datapath; full-rate throughput, tolerates backpressure.

Parameters:
- WIDTH, 32, operand width in bits; power of two, >= 4.
- STAGES, 2, number of register stages = latency in cycles; legal range 1..$clog2(WIDTH).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat this cycle
- in_data  in  WIDTH  operand
- in_count  in  $clog2(WIDTH)  shift amount, 0..WIDTH-1
- in_left  in  1  1 = shift/rotate left, 0 = right
- in_type  in  2  mode: 0 logical, 1 arithmetic, 2 rotate, 3 ones-fill
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  WIDTH  result

Behaviour:
- Reset (rst_n low at posedge): all stage valid bits clear; out_valid=0, out_data=0, in_ready=1 on the following cycle. Reset mid-operation discards all in-flight beats; no partial result is ever presented.
- Transfer occurs on posedge when valid && ready on the respective interface.
- Modes:
  - logical: vacated bits = 0.
  - arithmetic: right fills with in_data[WIDTH-1]; left identical to logical.
  - rotate: bits leaving one end re-enter the other.
  - ones-fill: vacated bits = 1, both directions.
- count=0 yields in_data unchanged in every mode.
- Shift levels: level k shifts by 2^k, k = 0..$clog2(WIDTH)-1.
  - P = ceil($clog2(WIDTH)/STAGES) levels per stage; level k is placed in stage floor(k/P).
  - Each stage registers its partial result plus remaining count bits, left and type.
  - Stages left empty by the rounding act as plain pipeline registers.
- Latency: exactly STAGES cycles from input transfer to out_valid with no stall.
- Each stage i holds valid[i]. Stage i loads when !valid[i] || ready_into_next[i].
  - The last stage's downstream ready is out_ready.
  - in_ready = !valid[0] || ready_into_next[0], combinational; no combinational path from in_valid to in_ready.
  - Bubbles collapse: a downstream stall never blocks an upstream empty stage.
- Full pipeline with out_ready=0: in_ready=0; all stage contents and out_data are held stable.
- Simultaneous input and output transfer when full: both accepted in the same cycle; throughput is 1 beat/cycle.
- out_data is held stable while out_valid && !out_ready.
- Results emerge strictly in input order; no beat is dropped or duplicated.

Optional Feature:
- Macro: PIPELINED_BARREL_FLAGS_EN.
- Defined: adds outputs out_carry (1) and out_zero (1), valid alongside out_data.
  - out_carry = last bit shifted out: in_data[WIDTH-count] for left, in_data[count-1] for right.
  - For count=0, out_carry=0.
  - For rotate, out_carry = the bit that wrapped last, i.e. out_data[0] for left and out_data[WIDTH-1] for right.
  - out_zero = (out_data == 0).
  - Both flags reset to 0 and are pipelined with their beat.
- Undefined: ports and logic are absent; the rest of the behaviour is unchanged.

Test Plan (WIDTH=32, STAGES=2 unless noted):
- Reset, then left logical, in_data=2, count=1 -> out_data=4 exactly 2 cycles after transfer. Then count=10 -> 0x00000800.
- Right arithmetic, in_data=0x80000000, count=2 -> 0xE0000000. Right logical, in_data=24, count=5 -> 0. Ones-fill left, in_data=7, count=3 -> 0x0000003F.
- Rotate left, in_data=0xE0000000, count=3 -> 0x00000007. Rotate right, in_data=7, count=3 -> 0xE0000000. count=0 in every mode -> unchanged.
- Backpressure: out_ready=0, stream 4 beats back-to-back.
  - in_ready drops after the 2nd accepted beat; out_data is held.
  - Raise out_ready -> results emerge in order, one per cycle, with in_ready=1 again.
- Reset mid-stream with 2 beats in flight: rst_n low 1 cycle -> out_valid=0 the next cycle, no stale beat ever appears. A new beat then yields its correct result.
- Flags build: right logical, in_data=1, count=1 -> out_data=0, out_carry=1, out_zero=1. Also sweep STAGES=1 and STAGES=5 with random stimulus against a reference model.
